// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the hazard controller
// Holds the FSM state encoding, the scoreboard entry layout, the scoreboard
// depth and the event counter width, plus a scoreboard match helper.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  localparam int SB_DEPTH = 3;
  localparam int CNT_W    = 16;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: 5'd0};

  // True when the entry holds a pending write to register rs.
  function automatic logic sb_match(input sb_entry_t e, input logic [4:0] rs);
    return e.valid && (e.rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat.sv
// rtl/pipeline_hazard_ctrl_sat.sv - saturating up-counter
// Ports:
//   CLK       rising-edge clock
//   RESET_N   asynchronous active-low reset, clears the count
//   cnt_inc   count one event this cycle
//   cnt_value current count, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         cnt_inc,
  output logic [W-1:0] cnt_value
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_value <= '0;
    end else if (cnt_inc && (cnt_value != CNT_MAX)) begin
      cnt_value <= cnt_value + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW stall / branch flush controller for a 5-stage pipeline
// Ports:
//   CLK, RESET_N                  clock, asynchronous active-low reset
//   ID_VALID                      IF/DI register holds a real instruction
//   ID_RS1, ID_RS2                decode source register fields
//   ID_USE_RS1, ID_USE_RS2        instruction really reads that source
//   ID_RD, ID_REGWRITE            decode destination field and write enable
//   BRANCH_TAKEN                  branch resolved taken at EX/ME
//   PC_HOLD, IFDI_HOLD            freeze PC and IF/DI
//   DIEX_BUBBLE                   zero the DI/EX control fields
//   IFDI_FLUSH, DIEX_FLUSH        discard wrong-path instructions
//   STATE                         FSM state (RUN/STALL/FLUSH)
//   STALL_CNT, FLUSH_CNT          saturating event counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ID_VALID,
  input  logic [4:0]        ID_RS1,
  input  logic [4:0]        ID_RS2,
  input  logic              ID_USE_RS1,
  input  logic              ID_USE_RS2,
  input  logic [4:0]        ID_RD,
  input  logic              ID_REGWRITE,
  input  logic              BRANCH_TAKEN,
  output logic              PC_HOLD,
  output logic              IFDI_HOLD,
  output logic              DIEX_BUBBLE,
  output logic              IFDI_FLUSH,
  output logic              DIEX_FLUSH,
  output logic [1:0]        STATE,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);

  // sb[0] tracks DI/EX, sb[1] EX/ME, sb[2] ME/WB. ME/WB is checked too
  // because the register file does not bypass a same-cycle write to a read.
  sb_entry_t sb [SB_DEPTH];
  hz_state_e state_q;

  logic      rs1_hit;
  logic      rs2_hit;
  logic      hazard;
  logic      stall_req;
  logic      flush_req;
  sb_entry_t issue_entry;

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_match(sb[i], ID_RS1)) rs1_hit = 1'b1;
      if (sb_match(sb[i], ID_RS2)) rs2_hit = 1'b1;
    end
  end

  // The cycle after a taken branch the decode slot holds a wrong-path
  // instruction being flushed, so any hazard it reports is ignored.
  assign hazard = ID_VALID
                && ((ID_USE_RS1 && (ID_RS1 != 5'd0) && rs1_hit)
                 || (ID_USE_RS2 && (ID_RS2 != 5'd0) && rs2_hit))
                && (state_q != ST_FLUSH);

  // RESET_N gating keeps every control output low for the whole reset,
  // whatever the other inputs are doing. The branch always wins over a stall.
  assign stall_req = RESET_N && hazard && !BRANCH_TAKEN;
  assign flush_req = RESET_N && BRANCH_TAKEN;

  assign PC_HOLD     = stall_req;
  assign IFDI_HOLD   = stall_req;
  assign DIEX_BUBBLE = stall_req;
  assign IFDI_FLUSH  = flush_req;
  assign DIEX_FLUSH  = flush_req;
  assign STATE       = state_q;

  // x0 writes are never tracked: x0 can never create a dependency.
  assign issue_entry = '{valid: ID_VALID && ID_REGWRITE && (ID_RD != 5'd0),
                         rd:    ID_RD};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < SB_DEPTH; i++) sb[i] <= SB_EMPTY;
    end else begin
      sb[0] <= (stall_req || flush_req) ? SB_EMPTY : issue_entry;
      // On a taken branch the DI/EX occupant is on the wrong path.
      sb[1] <= flush_req ? SB_EMPTY : sb[0];
      sb[2] <= sb[1];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_RUN;
    end else if (BRANCH_TAKEN) begin
      state_q <= ST_FLUSH;
    end else if (hazard) begin
      state_q <= ST_STALL;
    end else begin
      state_q <= ST_RUN;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .cnt_inc   (stall_req),
    .cnt_value (STALL_CNT)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .cnt_inc   (flush_req),
    .cnt_value (FLUSH_CNT)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        ID_VALID;
  logic [4:0]  ID_RS1, ID_RS2, ID_RD;
  logic        ID_USE_RS1, ID_USE_RS2, ID_REGWRITE;
  logic        BRANCH_TAKEN;
  logic        PC_HOLD, IFDI_HOLD, DIEX_BUBBLE, IFDI_FLUSH, DIEX_FLUSH;
  logic [1:0]  STATE;
  logic [15:0] STALL_CNT, FLUSH_CNT;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .ID_VALID     (ID_VALID),
    .ID_RS1       (ID_RS1),
    .ID_RS2       (ID_RS2),
    .ID_USE_RS1   (ID_USE_RS1),
    .ID_USE_RS2   (ID_USE_RS2),
    .ID_RD        (ID_RD),
    .ID_REGWRITE  (ID_REGWRITE),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .PC_HOLD      (PC_HOLD),
    .IFDI_HOLD    (IFDI_HOLD),
    .DIEX_BUBBLE  (DIEX_BUBBLE),
    .IFDI_FLUSH   (IFDI_FLUSH),
    .DIEX_FLUSH   (DIEX_FLUSH),
    .STATE        (STATE),
    .STALL_CNT    (STALL_CNT),
    .FLUSH_CNT    (FLUSH_CNT)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a list of issued register writes stamped with their
  // issue cycle. A writer blocks readers of its rd for the three cycles
  // after it issues; a taken branch cancels the writer issued one cycle
  // earlier. The cycle right after a branch ignores hazards.
  typedef struct {
    logic [4:0] rd;
    int         t;
  } wr_t;

  wr_t wq[$];
  int  cyc;
  bit  m_prev_br;
  int  m_state;
  int  m_stall;
  int  m_flush;

  logic [2:0]  obs_hold3, exp_hold3;
  logic [1:0]  obs_fl2,   exp_fl2;
  logic [1:0]  obs_state, exp_state;
  logic [15:0] obs_stall, exp_stall;
  logic [15:0] obs_fcnt,  exp_fcnt;

  function automatic bit busy(input logic [4:0] r);
    foreach (wq[i]) begin
      if (wq[i].rd == r && (cyc - wq[i].t) >= 1 && (cyc - wq[i].t) <= 3) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    wq.delete();
    cyc       = 0;
    m_prev_br = 1'b0;
    m_state   = 0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  // Applies one cycle of decode inputs, samples the DUT at the falling
  // edge into obs_*, computes exp_* from the model, then advances both.
  task automatic step(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2, input logic [4:0] rd,
                      input bit rw, input bit br);
    bit hz, h;
    ID_VALID = v; ID_RS1 = rs1; ID_RS2 = rs2; ID_USE_RS1 = u1; ID_USE_RS2 = u2;
    ID_RD = rd; ID_REGWRITE = rw; BRANCH_TAKEN = br;
    hz = v && ((u1 && rs1 != 5'd0 && busy(rs1)) || (u2 && rs2 != 5'd0 && busy(rs2)))
         && !m_prev_br;
    h  = hz && !br;
    exp_hold3 = {3{h}};
    exp_fl2   = {2{br}};
    exp_state = m_state[1:0];
    exp_stall = m_stall[15:0];
    exp_fcnt  = m_flush[15:0];
    @(negedge CLK);
    obs_hold3 = {PC_HOLD, IFDI_HOLD, DIEX_BUBBLE};
    obs_fl2   = {IFDI_FLUSH, DIEX_FLUSH};
    obs_state = STATE;
    obs_stall = STALL_CNT;
    obs_fcnt  = FLUSH_CNT;
    if (br) begin
      for (int i = wq.size() - 1; i >= 0; i--) if (wq[i].t == cyc - 1) wq.delete(i);
    end
    for (int i = wq.size() - 1; i >= 0; i--) if (cyc - wq[i].t >= 3) wq.delete(i);
    if (v && !h && !br && rw && rd != 5'd0) wq.push_back('{rd: rd, t: cyc});
    if (h  && m_stall < 65535) m_stall++;
    if (br && m_flush < 65535) m_flush++;
    m_state   = br ? 2 : (hz ? 1 : 0);
    m_prev_br = br;
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    ID_VALID = 1'b0; ID_RS1 = '0; ID_RS2 = '0; ID_USE_RS1 = 1'b0; ID_USE_RS2 = 1'b0;
    ID_RD = '0; ID_REGWRITE = 1'b0; BRANCH_TAKEN = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    ID_VALID = 1'b1; ID_RS1 = 5'd3; ID_USE_RS1 = 1'b1; BRANCH_TAKEN = 1'b1;
    RESET_N = 1'b0;
    #1;
    tests++;
    if ({PC_HOLD, IFDI_HOLD, DIEX_BUBBLE, IFDI_FLUSH, DIEX_FLUSH} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 00000",
               {PC_HOLD, IFDI_HOLD, DIEX_BUBBLE, IFDI_FLUSH, DIEX_FLUSH});
    end
    @(posedge CLK); #1;
    tests++;
    if (STATE !== 2'd0 || STALL_CNT !== 16'd0 || FLUSH_CNT !== 16'd0 || IFDI_FLUSH !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got state=%0d stall=%0d flush=%0d fl=%b want 0 0 0 0",
               STATE, STALL_CNT, FLUSH_CNT, IFDI_FLUSH);
    end
    do_reset();
  endtask

  task automatic test_raw_stall();
    int holds = 0;
    int st = 0;
    do_reset();
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0);
      tests++;
      if ({obs_hold3, obs_fl2, obs_state, obs_stall} !== {exp_hold3, exp_fl2, exp_state, exp_stall}) begin
        fails++;
        $display("FAIL raw_cycle%0d: got h=%b f=%b s=%0d c=%0d want h=%b f=%b s=%0d c=%0d", k,
                 obs_hold3, obs_fl2, obs_state, obs_stall, exp_hold3, exp_fl2, exp_state, exp_stall);
      end
      holds += obs_hold3[2];
      st    += (obs_state == 2'd1);
    end
    idle();
    st += (obs_state == 2'd1);
    tests++;
    if (holds != 3 || st != 3 || obs_stall !== 16'd3) begin
      fails++;
      $display("FAIL raw_stall: got holds=%0d stall_states=%0d cnt=%0d want 3 3 3", holds, st, obs_stall);
    end
  endtask

  task automatic test_x0();
    int holds = 0;
    do_reset();
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0);
      holds += obs_hold3[2];
    end
    idle();
    tests++;
    if (holds != 0 || obs_stall !== 16'd0) begin
      fails++;
      $display("FAIL x0_no_hazard: got holds=%0d cnt=%0d want 0 0", holds, obs_stall);
    end
  endtask

  task automatic test_store();
    int holds;
    for (int use2 = 1; use2 >= 0; use2--) begin
      holds = 0;
      do_reset();
      step(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
        step(1'b1, 5'd7, 5'd7, 1'b0, use2[0], 5'd0, 1'b0, 1'b0);
        tests++;
        if (obs_hold3 !== exp_hold3) begin
          fails++;
          $display("FAIL store_cycle%0d use2=%0d: got %b want %b", k, use2, obs_hold3, exp_hold3);
        end
        holds += obs_hold3[2];
      end
      tests++;
      if (holds != 2 * use2) begin
        fails++;
        $display("FAIL store_hold use2=%0d: got %0d want %0d", use2, holds, 2 * use2);
      end
    end
  endtask

  task automatic test_branch_hazard();
    do_reset();
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
    tests++;
    if (obs_hold3 !== 3'b000 || obs_fl2 !== 2'b11) begin
      fails++;
      $display("FAIL branch_wins: got hold=%b flush=%b want 000 11", obs_hold3, obs_fl2);
    end
    idle();
    tests++;
    if (obs_state !== 2'd2 || obs_fcnt !== 16'd1 || obs_stall !== 16'd0) begin
      fails++;
      $display("FAIL branch_next: got state=%0d fcnt=%0d scnt=%0d want 2 1 0", obs_state, obs_fcnt, obs_stall);
    end
    // x3 would sit in ME/WB and x4 in EX/ME now had they not been cancelled.
    step(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    tests++;
    if (obs_state !== 2'd0 || obs_hold3 !== 3'b000) begin
      fails++;
      $display("FAIL branch_sb_cleared: got state=%0d hold=%b want 0 000", obs_state, obs_hold3);
    end
  endtask

  task automatic test_reset_in_stall();
    int holds = 0;
    do_reset();
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    tests++;
    if (PC_HOLD !== 1'b1 || STATE !== 2'd1) begin
      fails++;
      $display("FAIL second_stall: got hold=%b state=%0d want 1 1", PC_HOLD, STATE);
    end
    RESET_N = 1'b0;
    #1;
    tests++;
    if ({PC_HOLD, IFDI_HOLD, DIEX_BUBBLE, IFDI_FLUSH, DIEX_FLUSH} !== 5'b0 ||
        STATE !== 2'd0 || STALL_CNT !== 16'd0 || FLUSH_CNT !== 16'd0) begin
      fails++;
      $display("FAIL reset_abort: got out=%b state=%0d scnt=%0d fcnt=%0d want 00000 0 0 0",
               {PC_HOLD, IFDI_HOLD, DIEX_BUBBLE, IFDI_FLUSH, DIEX_FLUSH}, STATE, STALL_CNT, FLUSH_CNT);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      holds += obs_hold3[2];
    end
    tests++;
    if (holds != 0 || obs_state !== 2'd0) begin
      fails++;
      $display("FAIL after_reset: got holds=%0d state=%0d want 0 0", holds, obs_state);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      step(($urandom % 4) != 0, 5'($urandom % 4), 5'($urandom % 4), 1'($urandom),
           1'($urandom), 5'($urandom % 4), 1'($urandom), ($urandom % 8) == 0);
      tests++;
      if ({obs_hold3, obs_fl2, obs_state, obs_stall, obs_fcnt} !==
          {exp_hold3, exp_fl2, exp_state, exp_stall, exp_fcnt}) begin
        fails++;
        $display("FAIL random_cycle%0d: got h=%b f=%b s=%0d sc=%0d fc=%0d want h=%b f=%b s=%0d sc=%0d fc=%0d",
                 k, obs_hold3, obs_fl2, obs_state, obs_stall, obs_fcnt,
                 exp_hold3, exp_fl2, exp_state, exp_stall, exp_fcnt);
      end
    end
  endtask

  task automatic test_saturation();
    int bad = 0;
    do_reset();
    // x1 <- x1 + 1 presented every cycle: each issue is followed by 3 stalls.
    for (int k = 0; k < 87500; k++) begin
      step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);
      if (obs_stall !== exp_stall || obs_hold3 !== exp_hold3) begin
        if (bad < 5)
          $display("FAIL sat_cycle%0d: got cnt=%0d h=%b want cnt=%0d h=%b",
                   k, obs_stall, obs_hold3, exp_stall, exp_hold3);
        bad++;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL sat_track: got %0d bad cycles want 0", bad);
    end
    tests++;
    if (obs_stall !== 16'hFFFF) begin
      fails++;
      $display("FAIL sat_hold: got %h want ffff", obs_stall);
    end
  endtask

  initial begin
    RESET_N = 1'b1;
    ID_VALID = 1'b0; ID_RS1 = '0; ID_RS2 = '0; ID_USE_RS1 = 1'b0; ID_USE_RS2 = 1'b0;
    ID_RD = '0; ID_REGWRITE = 1'b0; BRANCH_TAKEN = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_raw_stall();
    test_x0();
    test_store();
    test_branch_hazard();
    test_reset_in_stall();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
